// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared state encoding, channel ids and timeout response for the SPI arbiter
package spi_arb_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
    localparam logic CH_INERT = 1'b0;
    localparam logic CH_A2D = 1'b1;
    localparam logic [15:0] TMO_RESP = 16'hFFFF;
endpackage

// File: rtl/spi_req_slot.sv
// spi_req_slot: per-channel request latch, in-flight tracking and response register
module spi_req_slot (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [15:0] cmd,
    input  logic        grant,
    input  logic        fin,
    input  logic [15:0] fin_data,
    output logic        pending,
    output logic [15:0] hold_cmd,
    output logic [15:0] resp,
    output logic        done,
    output logic        ovr
);
    logic in_flight;
    // A channel owns at most one request from capture until its completion edge
    assign ovr = req & (pending | in_flight);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= 1'b0;
            in_flight <= 1'b0;
            hold_cmd  <= 16'h0000;
            resp      <= 16'h0000;
            done      <= 1'b0;
        end else begin
            pending   <= (req & ~ovr) | (pending & ~grant);
            in_flight <= grant | (in_flight & ~fin);
            hold_cmd  <= (req & ~ovr) ? cmd : hold_cmd;
            resp      <= fin ? fin_data : resp;
            done      <= fin;
        end
    end
endmodule

// File: rtl/spi_arb2.sv
// spi_arb2: round-robin arbiter sharing one 16-bit SPI master between the inertial and A2D interfaces
module spi_arb2
    import spi_arb_pkg::*;
#(
    parameter int GAP_CYCLES  = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic [15:0] cmd0,
    output logic        done0,
    output logic [15:0] resp0,
    input  logic        req1,
    input  logic [15:0] cmd1,
    output logic        done1,
    output logic [15:0] resp1,
    output logic        mstr_wrt,
    output logic [15:0] mstr_cmd,
    input  logic        mstr_done,
    input  logic [15:0] mstr_rd_data,
    output logic        ss_sel,
    output logic        busy,
    output logic        err_ovr,
    output logic        err_tmo
);
    localparam int TW = $clog2(TIMEOUT_CYC);

    state_t        state;
    logic          last_grant;
    logic [TW-1:0] tmo_cnt;
    logic [3:0]    gap_cnt;
    logic [1:0]    pend, ovr;
    logic [15:0]   hold0, hold1, fin_data;
    logic          any, win, grant, tmo_hit, fin;

    assign any      = |pend;
    // On a tie the channel that was not served last wins
    assign win      = &pend ? ~last_grant : pend[1];
    assign grant    = (state == IDLE) & any;
    assign tmo_hit  = tmo_cnt == TW'(TIMEOUT_CYC - 1);
    assign fin      = (state == BUSY) & (mstr_done | tmo_hit);
    assign fin_data = mstr_done ? mstr_rd_data : TMO_RESP;
    assign busy     = state != IDLE;

    spi_req_slot u_slot0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .cmd(cmd0),
        .grant(grant & ~win), .fin(fin & ~ss_sel), .fin_data(fin_data),
        .pending(pend[0]), .hold_cmd(hold0), .resp(resp0), .done(done0), .ovr(ovr[0])
    );

    spi_req_slot u_slot1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .cmd(cmd1),
        .grant(grant & win), .fin(fin & ss_sel), .fin_data(fin_data),
        .pending(pend[1]), .hold_cmd(hold1), .resp(resp1), .done(done1), .ovr(ovr[1])
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= CH_A2D;
            mstr_wrt   <= 1'b0;
            mstr_cmd   <= 16'h0000;
            ss_sel     <= CH_INERT;
            tmo_cnt    <= '0;
            gap_cnt    <= '0;
            err_ovr    <= 1'b0;
            err_tmo    <= 1'b0;
        end else begin
            err_ovr  <= err_ovr | (|ovr);
            mstr_wrt <= grant;
            case (state)
                IDLE: if (any) begin
                    mstr_cmd   <= win ? hold1 : hold0;
                    ss_sel     <= win;
                    last_grant <= win;
                    tmo_cnt    <= '0;
                    state      <= BUSY;
                end
                BUSY: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (fin) begin
                        err_tmo <= err_tmo | ~mstr_done;
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                    if (gap_cnt == 4'(GAP_CYCLES - 1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_arb2.sv
// tb_spi_arb2: directed checks of capture, arbitration, gap, timeout and reset for spi_arb2
module tb_spi_arb2;
    logic clk = 1'b0, rst_n = 1'b0;
    logic req0 = 1'b0, req1 = 1'b0;
    logic [15:0] cmd0 = 16'h0, cmd1 = 16'h0;
    logic done0, done1, mstr_wrt, ss_sel, busy, err_ovr, err_tmo;
    logic [15:0] resp0, resp1, mstr_cmd, mstr_rd_data;
    logic mstr_done;
    logic m_done = 1'b0, t_done = 1'b0, model_en = 1'b1;
    logic [15:0] m_data = 16'h0, t_data = 16'h0;
    int vec = 0, errs = 0;
    int wrt_n = 0, d0_n = 0, d1_n = 0;
    logic wrt_ss [64];

    assign mstr_done    = m_done | t_done;
    assign mstr_rd_data = m_done ? m_data : t_data;

    spi_arb2 dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .cmd0(cmd0), .done0(done0), .resp0(resp0),
        .req1(req1), .cmd1(cmd1), .done1(done1), .resp1(resp1),
        .mstr_wrt(mstr_wrt), .mstr_cmd(mstr_cmd), .mstr_done(mstr_done),
        .mstr_rd_data(mstr_rd_data), .ss_sel(ss_sel), .busy(busy),
        .err_ovr(err_ovr), .err_tmo(err_tmo)
    );

    always #5 clk = ~clk;

    // SPI master model: answers cmd ^ 16'h8DA5 with done four cycles after wrt
    initial forever begin
        @(negedge clk);
        if (mstr_wrt && model_en) begin
            repeat (3) @(negedge clk);
            m_data = mstr_cmd ^ 16'h8DA5;
            m_done = 1'b1;
            @(negedge clk);
            m_done = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (mstr_wrt) begin
            if (wrt_n < 64) wrt_ss[wrt_n] = ss_sel;
            wrt_n++;
        end
        if (done0) d0_n++;
        if (done1) d1_n++;
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; t_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_sig(input int which, input int budget, output int cyc, output bit ok);
        ok = 1'b0;
        cyc = 0;
        while (!ok && cyc < budget) begin
            @(negedge clk);
            cyc++;
            case (which)
                0: ok = done0;
                1: ok = done1;
                2: ok = mstr_wrt;
                default: ok = done0 | done1;
            endcase
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        vec++;
        if ({busy, mstr_wrt, ss_sel, err_ovr, err_tmo, done0, done1} !== 7'b0) begin
            errs++; $display("FAIL reset_flags got %b need 0000000", {busy, mstr_wrt, ss_sel, err_ovr, err_tmo, done0, done1});
        end
        vec++;
        if ({resp0, resp1, mstr_cmd} !== 48'h0) begin
            errs++; $display("FAIL reset_data got %h need 0", {resp0, resp1, mstr_cmd});
        end
        do_reset();
    endtask

    task automatic test_single();
        int c, b1; bit ok;
        b1 = d1_n;
        @(negedge clk);
        req0 = 1'b1; cmd0 = 16'h8D00;
        @(negedge clk);
        req0 = 1'b0;
        vec++;
        if (mstr_wrt !== 1'b0) begin errs++; $display("FAIL single_wrt_early got %b need 0", mstr_wrt); end
        @(negedge clk);
        vec++;
        if ({mstr_wrt, ss_sel, busy, mstr_cmd} !== {3'b101, 16'h8D00}) begin
            errs++; $display("FAIL single_issue got wrt/ss/busy/cmd %b%b%b/%h need 101/8d00", mstr_wrt, ss_sel, busy, mstr_cmd);
        end
        @(negedge clk);
        vec++;
        if (mstr_wrt !== 1'b0) begin errs++; $display("FAIL single_wrt_width got %b need 0", mstr_wrt); end
        wait_sig(0, 30, c, ok);
        vec++;
        if (!ok || resp0 !== 16'h00A5) begin errs++; $display("FAIL single_done0 got ok=%b resp0=%h need 1/00a5", ok, resp0); end
        @(negedge clk);
        vec++;
        if (done0 !== 1'b0) begin errs++; $display("FAIL single_done0_width got %b need 0", done0); end
        vec++;
        if (d1_n != b1) begin errs++; $display("FAIL single_no_done1 got %0d need 0", d1_n - b1); end
    endtask

    task automatic test_simultaneous();
        int c; bit ok;
        do_reset();
        req0 = 1'b1; cmd0 = 16'h1111; req1 = 1'b1; cmd1 = 16'h2222;
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        wait_sig(0, 30, c, ok);
        vec++;
        if (!ok || resp0 !== 16'h9CB4 || done1 !== 1'b0) begin
            errs++; $display("FAIL simul_first got ok=%b resp0=%h done1=%b need 1/9cb4/0", ok, resp0, done1);
        end
        wait_sig(2, 30, c, ok);
        vec++;
        if (!ok || c != 3) begin errs++; $display("FAIL simul_gap got ok=%b cycles=%0d need 1/3", ok, c); end
        vec++;
        if (ss_sel !== 1'b1 || mstr_cmd !== 16'h2222) begin
            errs++; $display("FAIL simul_second_issue got ss=%b cmd=%h need 1/2222", ss_sel, mstr_cmd);
        end
        wait_sig(1, 30, c, ok);
        vec++;
        if (!ok || resp1 !== 16'hAF87 || ss_sel !== 1'b1 || err_ovr !== 1'b0) begin
            errs++; $display("FAIL simul_second_done got ok=%b resp1=%h ss=%b ovr=%b need 1/af87/1/0", ok, resp1, ss_sel, err_ovr);
        end
    endtask

    task automatic test_round_robin();
        int c, base; bit ok, ch; logic [5:0] seq;
        do_reset();
        base = wrt_n;
        req0 = 1'b1; cmd0 = 16'h0101; req1 = 1'b1; cmd1 = 16'h0202;
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        for (int t = 0; t < 6; t++) begin
            wait_sig(3, 40, c, ok);
            vec++;
            if (!ok) begin errs++; $display("FAIL rr_done_%0d got timeout need done", t); end
            ch = done1;
            if (t < 5) begin
                if (ch) req1 = 1'b1; else req0 = 1'b1;
                @(negedge clk);
                req0 = 1'b0; req1 = 1'b0;
            end
        end
        for (int i = 0; i < 6; i++) seq[i] = wrt_ss[base + i];
        vec++;
        if (wrt_n - base != 6 || seq !== 6'b101010) begin
            errs++; $display("FAIL rr_sequence got n=%0d ss(lsb first)=%b need 6/101010", wrt_n - base, seq);
        end
    endtask

    task automatic test_overflow();
        int c, base; bit ok;
        do_reset();
        base = wrt_n;
        req0 = 1'b1; cmd0 = 16'h0055;
        @(negedge clk);
        cmd0 = 16'h0066;
        @(negedge clk);
        req0 = 1'b0;
        wait_sig(0, 30, c, ok);
        repeat (10) @(negedge clk);
        vec++;
        if (!ok || err_ovr !== 1'b1 || wrt_n - base != 1 || resp0 !== (16'h0055 ^ 16'h8DA5)) begin
            errs++; $display("FAIL ovr_pending got ok=%b ovr=%b wrts=%0d resp0=%h need 1/1/1/8df0", ok, err_ovr, wrt_n - base, resp0);
        end
        do_reset();
        model_en = 1'b0;
        base = wrt_n;
        req0 = 1'b1; cmd0 = 16'h0077;
        @(negedge clk);
        req0 = 1'b0;
        wait_sig(2, 10, c, ok);
        repeat (2) @(negedge clk);
        vec++;
        if (!ok || err_ovr !== 1'b0) begin errs++; $display("FAIL ovr_clean got ok=%b ovr=%b need 1/0", ok, err_ovr); end
        t_done = 1'b1; t_data = 16'h1234; req0 = 1'b1; cmd0 = 16'h0088;
        @(negedge clk);
        t_done = 1'b0; req0 = 1'b0;
        vec++;
        if (done0 !== 1'b1 || resp0 !== 16'h1234 || err_ovr !== 1'b1) begin
            errs++; $display("FAIL ovr_done_edge got done0=%b resp0=%h ovr=%b need 1/1234/1", done0, resp0, err_ovr);
        end
        repeat (10) @(negedge clk);
        vec++;
        if (wrt_n - base != 1 || busy !== 1'b0) begin
            errs++; $display("FAIL ovr_no_reissue got wrts=%0d busy=%b need 1/0", wrt_n - base, busy);
        end
        model_en = 1'b1;
    endtask

    task automatic test_timeout();
        int c; bit ok;
        do_reset();
        model_en = 1'b0;
        req0 = 1'b1; cmd0 = 16'h4444;
        @(negedge clk);
        req0 = 1'b0;
        wait_sig(2, 10, c, ok);
        wait_sig(0, 5000, c, ok);
        vec++;
        if (!ok || c != 4096 || resp0 !== 16'hFFFF || err_tmo !== 1'b1) begin
            errs++; $display("FAIL timeout got ok=%b cycles=%0d resp0=%h tmo=%b need 1/4096/ffff/1", ok, c, resp0, err_tmo);
        end
        model_en = 1'b1;
        req1 = 1'b1; cmd1 = 16'h1234;
        @(negedge clk);
        req1 = 1'b0;
        wait_sig(1, 40, c, ok);
        vec++;
        if (!ok || resp1 !== 16'h9F91 || err_tmo !== 1'b1) begin
            errs++; $display("FAIL timeout_recover got ok=%b resp1=%h tmo=%b need 1/9f91/1", ok, resp1, err_tmo);
        end
    endtask

    task automatic test_reset_mid();
        int c, b1; bit ok;
        do_reset();
        model_en = 1'b0;
        req1 = 1'b1; cmd1 = 16'h4321;
        @(negedge clk);
        req1 = 1'b0;
        wait_sig(2, 10, c, ok);
        @(negedge clk);
        vec++;
        if (!ok || busy !== 1'b1 || ss_sel !== 1'b1) begin
            errs++; $display("FAIL mid_busy got ok=%b busy=%b ss=%b need 1/1/1", ok, busy, ss_sel);
        end
        #2 rst_n = 1'b0;
        #1;
        vec++;
        if ({busy, ss_sel, mstr_wrt, done1} !== 4'b0 || mstr_cmd !== 16'h0) begin
            errs++; $display("FAIL mid_async got busy/ss/wrt/done1=%b cmd=%h need 0000/0000", {busy, ss_sel, mstr_wrt, done1}, mstr_cmd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        b1 = d1_n;
        t_done = 1'b1; t_data = 16'hDEAD;
        @(negedge clk);
        t_done = 1'b0;
        repeat (6) @(negedge clk);
        vec++;
        if (d1_n != b1 || resp1 !== 16'h0000) begin
            errs++; $display("FAIL mid_no_done got done1s=%0d resp1=%h need 0/0000", d1_n - b1, resp1);
        end
        model_en = 1'b1;
        req1 = 1'b1; cmd1 = 16'h4321;
        @(negedge clk);
        req1 = 1'b0;
        wait_sig(1, 40, c, ok);
        vec++;
        if (!ok || resp1 !== 16'hCE84) begin errs++; $display("FAIL mid_fresh got ok=%b resp1=%h need 1/ce84", ok, resp1); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_round_robin();
        test_overflow();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/spi_arb2.md
Name: spi_arb2

Overview:
- Shares one 16-bit SPI master (SPI_mstr16) between two requesters: channel 0 = inert_intf (NEMO inertial sensor), channel 1 = A2D_intf (load cells/battery).
- Latches single-cycle requests and arbitrates round-robin.
- Drives the master's wrt/cmd, steers the slave-select via ss_sel, and returns read data with a done pulse to the winning requester.
- Enforces a minimum SS_n-high gap between transactions and aborts hung transactions on timeout.

Parameters:
GAP_CYCLES, 2, idle clocks between mstr_done and the next mstr_wrt (range 1..15)
TIMEOUT_CYC, 4096, clocks in BUSY before abort (power of 2, at least 64)

Ports:
clk  in  1  system clock, all logic posedge
rst_n  in  1  asynchronous active-low reset
req0  in  1  ch0 transaction request, single-cycle pulse
cmd0  in  16  ch0 SPI command word, sampled when req0=1
done0  out  1  ch0 transaction complete, one-cycle pulse
resp0  out  16  ch0 read data, valid from done0 and held until next ch0 completion
req1/cmd1/done1/resp1  same as ch0, for ch1
mstr_wrt  out  1  start pulse to SPI master
mstr_cmd  out  16  command to SPI master, stable from mstr_wrt until completion
mstr_done  in  1  SPI master transaction complete
mstr_rd_data  in  16  SPI master read data, valid with mstr_done
ss_sel  out  1  0 routes SS_n to the inertial sensor, 1 to the A2D; held through the transaction
busy  out  1  high in any state other than IDLE
err_ovr  out  1  sticky; a request was dropped
err_tmo  out  1  sticky; a transaction timed out

Behaviour:
- Reset (async):
  - state=IDLE; all pending/in-flight flags cleared, last_grant=1 (ch0 wins the first tie).
  - All outputs 0; resp0/resp1=16'h0000; mstr_cmd=16'h0000.
  - A reset mid-transaction abandons it silently; no done pulse.
- Request capture:
  - reqN is accepted at a clk edge iff chN is neither pending nor in flight at that edge; cmdN is copied into holding register N.
  - Otherwise the request is dropped and err_ovr is set.
  - In flight lasts from grant through the edge that samples mstr_done (or timeout), inclusive. A reqN on that edge is dropped.
  - Both channels may request on the same edge; both are accepted.
- States:
  - IDLE: if any channel is pending, grant one.
    - Both pending: the channel not equal to last_grant wins.
    - Grant edge: mstr_cmd <- holding cmd, ss_sel <- channel, last_grant <- channel, mstr_wrt <- 1, pending cleared, in-flight set. Go to BUSY.
  - BUSY: mstr_wrt drops to 0 on the first BUSY edge (exactly one-cycle pulse). The timeout counter starts at 0 on BUSY entry.
    - mstr_done=1: respN <- mstr_rd_data, doneN <- 1 for one cycle, in-flight cleared. Go to GAP.
    - Counter reaches TIMEOUT_CYC-1 without mstr_done: respN <- 16'hFFFF, doneN pulse, err_tmo set. Go to GAP.
  - GAP: wait GAP_CYCLES clocks, then go to IDLE. ss_sel holds its value. mstr_done is ignored in GAP and IDLE.
- Latency:
  - reqN at edge k in an idle system: mstr_wrt is high in the cycle after edge k+1.
  - mstr_done at edge m: doneN is high in the cycle after edge m.
  - Minimum spacing between mstr_wrt pulses is 2 + GAP_CYCLES + the master's own latency.
- Fairness: under continuous requests from both channels, grants strictly alternate.
- err_ovr and err_tmo clear only on reset.

Decomposition:
- Package spi_arb_pkg:
  - state enum {IDLE, BUSY, GAP}
  - CH_INERT=1'b0, CH_A2D=1'b1
  - TMO_RESP=16'h FFFF
- Sub-module spi_req_slot, instantiated twice:
  - Contains the pending flag, the in-flight flag, the cmd holding register and the resp register.
  - Produces the accept/overflow decision for its channel.
- The top level holds the FSM, arbiter, gap counter and timeout counter.

Test Plan:
- Single ch0 request: req0 with cmd0=16'h8D00; model returns 16'h00A5 four cycles after wrt. Required: mstr_wrt one cycle with mstr_cmd=16'h8D00 and ss_sel=0; done0 one cycle with resp0=16'h00A5; done1 never pulses.
- Simultaneous requests: req0 and req1 on the same edge after reset. Required: ch0 served first and ch1 second; the second mstr_wrt occurs at least GAP_CYCLES+1 cycles after the first done; ss_sel=1 during the ch1 transaction.
- Round-robin: both channels re-request immediately after each done, for 6 transactions. Required: ss_sel sequence 0,1,0,1,0,1.
- Overflow: req0 while ch0 is pending, and req0 on the mstr_done edge. Required: err_ovr=1; only one ch0 transaction issued per accepted request.
- Timeout: model never asserts mstr_done. Required: done0 at 4096 cycles into BUSY with resp0=16'hFFFF; err_tmo=1; a later ch1 request still completes normally.
- Reset mid-BUSY: rst_n low for 1 cycle during a ch1 transaction. Required: all outputs 0 immediately (asynchronously); no done1; a fresh request afterwards completes.
